st_frame_rx: RTL and testbench

Serial frame receiver that consumes the `tx_out` stream produced by a neighbouring layer's `self_test` block and turns it back into 32-bit words. It checks each frame's start, parity, stop and header fields. Good words go onto a parallel bus with a one-cycle valid strobe; bad frames raise exactly one error pulse. It sits directly downstream of `self_test` in the inter-layer test path, on the same clock.

---
 rtl/st_frame_rx.sv | 112 +++++++++++
 tb/tb_st_frame_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/st_frame_rx.sv
// Serial frame receiver: start / DATA_W payload bits MSB first / even parity / stop.
// Good words go out on a parallel bus with a one-cycle strobe; bad frames raise one error pulse.
module st_frame_rx #(
    parameter int                DATA_W  = 32,
    parameter int                HDR_W   = 4,
    parameter logic [HDR_W-1:0]  HDR_VAL = 4'b1010,
    parameter int                CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              hdr_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_BREAK,
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bit_cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic                par_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                valid_q, par_err_q, frm_err_q, hdr_err_q;

    logic                good_d, par_err_d, frm_err_d, hdr_err_d;

    // State register. BREAK after reset keeps a low line (upstream still in reset)
    // from being taken as a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BREAK;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BREAK:  if (rx_in)  state_d = S_IDLE;
            S_IDLE:   if (!rx_in) state_d = S_DATA;
            S_DATA:   if (bit_cnt_q == LAST_BIT) state_d = S_PARITY;
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = rx_in ? S_IDLE : S_BREAK;
            default:  state_d = S_BREAK;
        endcase
    end

    // Frame evaluation on the stop bit; priority frm > par > hdr > good.
    always_comb begin
        good_d    = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        hdr_err_d = 1'b0;
        if (state_q == S_STOP) begin
            if (!rx_in)                                     frm_err_d = 1'b1;
            else if ((^shift_q) != par_q)                   par_err_d = 1'b1;
            else if (shift_q[DATA_W-1 -: HDR_W] != HDR_VAL) hdr_err_d = 1'b1;
            else                                            good_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            data_out_q <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            hdr_err_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE) bit_cnt_q <= '0;
            if (state_q == S_DATA) begin
                bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                shift_q   <= {shift_q[DATA_W-2:0], rx_in};
            end
            if (state_q == S_PARITY) par_q <= rx_in;
            if (good_d) begin
                data_out_q <= shift_q;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
            valid_q   <= good_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            hdr_err_q <= hdr_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign frm_err    = frm_err_q;
    assign hdr_err    = hdr_err_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_st_frame_rx.sv
// Bench for st_frame_rx: directed frames plus randomized frames against a frame-level
// reference model (expected outcome derived from payload, parity and stop bit).
module tb_st_frame_rx;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_in = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid, par_err, frm_err, hdr_err;
    logic [CNT_W-1:0]  frame_cnt;

    st_frame_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .par_err    (par_err),
        .frm_err    (frm_err),
        .hdr_err    (hdr_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Pulse monitor: counts every high cycle of each result strobe.
    int n_valid = 0, n_par = 0, n_frm = 0, n_hdr = 0;
    int valid_cyc = 0;
    always @(negedge clk) begin
        if (data_valid) begin n_valid++; valid_cyc = cyc; end
        if (par_err) n_par++;
        if (frm_err) n_frm++;
        if (hdr_err) n_hdr++;
    end

    // Reference model state.
    logic [DATA_W-1:0] m_data = '0;
    int m_cnt = 0;
    int e_valid = 0, e_par = 0, e_frm = 0, e_hdr = 0;
    int start_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        @(negedge clk);
    endtask

    task automatic idle(input logic b, input int n);
        repeat (n) send_bit(b);
    endtask

    task automatic check_counts();
        check("n_valid", n_valid, e_valid);
        check("n_par",   n_par,   e_par);
        check("n_frm",   n_frm,   e_frm);
        check("n_hdr",   n_hdr,   e_hdr);
    endtask

    // Sends one full frame; checks the result cycle right after the stop bit.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par_flip, input logic stop);
        logic par;
        int   kind;
        par = (^d) ^ par_flip;
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(d[i]);
        send_bit(par);
        rx_in = stop;
        @(negedge clk);
        if (!stop)                 kind = 1;
        else if (par != (^d))      kind = 2;
        else if (d[31:28] != 4'hA) kind = 3;
        else                       kind = 0;
        case (kind)
            0: begin
                m_data = d;
                if (m_cnt < 255) m_cnt++;
                e_valid++;
            end
            1: e_frm++;
            2: e_par++;
            default: e_hdr++;
        endcase
        check("data_valid", data_valid, kind == 0);
        check("frm_err",    frm_err,    kind == 1);
        check("par_err",    par_err,    kind == 2);
        check("hdr_err",    hdr_err,    kind == 3);
        check("data_out",   data_out,   m_data);
        check("frame_cnt",  frame_cnt,  m_cnt);
        #1;
        check_counts();
        if (kind == 0) check("valid_latency", valid_cyc - start_cyc, 35);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  h;
        int          first_valid;
        int          k;

        // Reset with the line low, as while upstream is in reset.
        rst_n = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out",  data_out,   0);
        check("rst_valid",     data_valid, 0);
        check("rst_errs",      {par_err, frm_err, hdr_err}, 0);
        check("rst_frame_cnt", frame_cnt,  0);
        rst_n = 1'b1;
        idle(1'b0, 3);
        #1;
        check_counts();
        idle(1'b1, 2);

        // Good frame.
        send_frame(32'hA201BEAF, 1'b0, 1'b1);

        // Back-to-back good frames.
        send_frame(32'hA612BEAF, 1'b0, 1'b1);
        first_valid = valid_cyc;
        send_frame(32'hA623BEAF, 1'b0, 1'b1);
        check("b2b_spacing", valid_cyc - first_valid, 35);
        check("b2b_data", data_out, 32'hA623BEAF);
        check("b2b_cnt",  frame_cnt, 3);

        // Parity error.
        idle(1'b1, 1);
        send_frame(32'hA623BEAF, 1'b1, 1'b1);

        // Frame error, long low line, then recovery.
        idle(1'b1, 1);
        send_frame(32'hA201BEAF, 1'b0, 1'b0);
        idle(1'b0, 10);
        idle(1'b1, 1);
        #1;
        check_counts();
        send_frame(32'hA5A5_0001, 1'b0, 1'b1);

        // Header error.
        send_frame(32'h5201BEAF, 1'b0, 1'b1);

        // Reset mid-frame after 12 payload bits.
        idle(1'b1, 2);
        r = 32'hA123_4567;
        send_bit(1'b0);
        for (int i = 31; i >= 20; i--) send_bit(r[i]);
        #2 rst_n = 1'b0;
        #1;
        m_data = '0;
        m_cnt  = 0;
        check("midrst_data_out",  data_out,   0);
        check("midrst_frame_cnt", frame_cnt,  0);
        check("midrst_pulses",    {data_valid, par_err, frm_err, hdr_err}, 0);
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0, 40);
        #1;
        check_counts();
        check("postrst_frame_cnt", frame_cnt, 0);
        idle(1'b1, 1);
        send_frame(32'hAFFF_0000, 1'b0, 1'b1);

        // Randomized good frames, long enough to saturate the counter.
        for (int n = 0; n < 260; n++) begin
            r = $urandom();
            send_frame({4'hA, r[27:0]}, 1'b0, 1'b1);
            idle(1'b1, $urandom_range(0, 2));
        end
        check("sat_frame_cnt", frame_cnt, 255);

        // Randomized mix of good and bad frames.
        for (int n = 0; n < 60; n++) begin
            r = $urandom();
            k = $urandom_range(0, 3);
            case (k)
                0: send_frame({4'hA, r[27:0]}, 1'b0, 1'b1);
                1: send_frame({4'hA, r[27:0]}, 1'b1, 1'b1);
                2: send_frame({4'hA, r[27:0]}, $urandom_range(0, 1), 1'b0);
                default: begin
                    h = 4'($urandom_range(0, 15));
                    if (h == 4'hA) h = 4'h5;
                    send_frame({h, r[27:0]}, 1'b0, 1'b1);
                end
            endcase
            if (k == 2) begin
                idle(1'b0, $urandom_range(0, 3));
                idle(1'b1, $urandom_range(1, 2));
            end else begin
                idle(1'b1, $urandom_range(0, 2));
            end
        end
        #1;
        check_counts();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
